// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - MIPS-32 instruction decode stage with ID/EX register (optional skid entry: ID_SKID_EN)
module instr_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [4:0]  aluctrl,
  output logic        i_type,
  output logic [31:0] imm,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        illegal
);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  aluctrl;
    logic        i_type;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } dec_t;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_SLL  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b01110;
  localparam logic [4:0] ALU_SRA  = 5'b01111;
  localparam logic [4:0] ALU_SLT  = 5'b10000;
  localparam logic [4:0] ALU_BEQ  = 5'b10010;
  localparam logic [4:0] ALU_BGTZ = 5'b10011;
  localparam logic [4:0] ALU_BGEZ = 5'b10100;
  localparam logic [4:0] ALU_LUI  = 5'b10101;
  localparam logic [4:0] ALU_BNE  = 5'b10110;
  localparam logic [4:0] ALU_ILL  = 5'b11111;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] sext;
  logic [31:0] zext;
  logic        accept;
  logic        out_valid_q;
  dec_t        dec;
  dec_t        out_q;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign sext   = {{16{instr[15]}}, instr[15:0]};
  assign zext   = {16'b0, instr[15:0]};

  // Combinational translation of the incoming word into execute-stage controls
  always_comb begin
    dec    = '0;
    dec.pc = pc_in;
    dec.rs = instr[25:21];
    dec.rt = instr[20:16];
    case (opcode)
      6'h00: begin
        dec.dest      = instr[15:11];
        dec.reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: dec.aluctrl = ALU_ADD;
          6'h22, 6'h23: dec.aluctrl = ALU_SUB;
          6'h24:        dec.aluctrl = ALU_AND;
          6'h25:        dec.aluctrl = ALU_OR;
          6'h27:        dec.aluctrl = ALU_NOR;
          6'h2A:        dec.aluctrl = ALU_SLT;
          6'h00: begin dec.aluctrl = ALU_SLL; dec.imm = {27'b0, instr[10:6]}; end
          6'h02: begin dec.aluctrl = ALU_SRL; dec.imm = {27'b0, instr[10:6]}; end
          6'h03: begin dec.aluctrl = ALU_SRA; dec.imm = {27'b0, instr[10:6]}; end
          default:      dec.illegal = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin
        dec.aluctrl = ALU_ADD; dec.i_type = 1'b1; dec.imm = sext;
        dec.dest = instr[20:16]; dec.reg_write = 1'b1;
      end
      6'h0A: begin
        dec.aluctrl = ALU_SLT; dec.i_type = 1'b1; dec.imm = sext;
        dec.dest = instr[20:16]; dec.reg_write = 1'b1;
      end
      6'h0C: begin
        dec.aluctrl = ALU_AND; dec.i_type = 1'b1; dec.imm = zext;
        dec.dest = instr[20:16]; dec.reg_write = 1'b1;
      end
      6'h0D: begin
        dec.aluctrl = ALU_OR; dec.i_type = 1'b1; dec.imm = zext;
        dec.dest = instr[20:16]; dec.reg_write = 1'b1;
      end
      6'h0F: begin
        dec.aluctrl = ALU_LUI; dec.i_type = 1'b1; dec.imm = zext;
        dec.dest = instr[20:16]; dec.reg_write = 1'b1;
      end
      6'h23: begin
        dec.aluctrl = ALU_ADD; dec.i_type = 1'b1; dec.imm = sext;
        dec.dest = instr[20:16]; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
      end
      6'h2B: begin
        dec.aluctrl = ALU_ADD; dec.i_type = 1'b1; dec.imm = sext;
        dec.dest = instr[20:16]; dec.mem_write = 1'b1;
      end
      // Branches compare registers in the ALU; no writeback target
      6'h04: begin dec.aluctrl = ALU_BEQ;  dec.imm = sext; dec.branch = 1'b1; end
      6'h05: begin dec.aluctrl = ALU_BNE;  dec.imm = sext; dec.branch = 1'b1; end
      6'h07: begin dec.aluctrl = ALU_BGTZ; dec.imm = sext; dec.branch = 1'b1; end
      6'h01: begin
        if (instr[20:16] == 5'd1) begin
          dec.aluctrl = ALU_BGEZ; dec.imm = sext; dec.branch = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to r0 are architecturally discarded
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
    // Unknown encodings leave no side effects downstream
    if (dec.illegal) begin
      dec.aluctrl   = ALU_ILL;
      dec.i_type    = 1'b0;
      dec.imm       = '0;
      dec.dest      = '0;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
    end
  end

`ifdef ID_SKID_EN
  dec_t skid_q;
  logic skid_valid;
  logic in_ready_q;

  assign in_ready = in_ready_q;
  assign accept   = in_valid & in_ready_q;

  // ID/EX register plus one skid slot; in_ready is registered as "skid empty"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (out_valid_q && !out_ready) begin
      if (accept) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
      in_ready_q <= ~(skid_valid | accept);
    end else if (skid_valid) begin
      out_q       <= skid_q;
      out_valid_q <= 1'b1;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (accept) out_q <= dec;
      out_valid_q <= accept;
      in_ready_q  <= 1'b1;
    end
  end
`else
  assign in_ready = rst_n & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // ID/EX register: reload on accept, drain on consume, kill on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign pc_out    = out_q.pc;
  assign aluctrl   = out_q.aluctrl;
  assign i_type    = out_q.i_type;
  assign imm       = out_q.imm;
  assign rs        = out_q.rs;
  assign rt        = out_q.rt;
  assign dest      = out_q.dest;
  assign reg_write = out_q.reg_write;
  assign mem_read  = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign branch    = out_q.branch;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - scoreboard bench for instr_decode against a table-driven decode model
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [4:0]  aluctrl;
  logic        i_type;
  logic [31:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  dest;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        illegal;

  instr_decode dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .aluctrl(aluctrl), .i_type(i_type), .imm(imm), .rs(rs), .rt(rt), .dest(dest),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  alu;
    logic        ity;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;
  exp_t q[$];

  logic [4:0] r_alu [int];
  logic [4:0] i_alu [int];
  logic [5:0] funct_pool [0:11];
  logic [5:0] op_pool [0:11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode rules expressed as lookup tables and field arithmetic
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int op, fn, rtf;
    logic [31:0] se, ze;
    op  = int'(w[31:26]);
    fn  = int'(w[5:0]);
    rtf = int'(w[20:16]);
    se  = {{16{w[15]}}, w[15:0]};
    ze  = {16'h0000, w[15:0]};
    e = '0;
    e.pc = pc; e.rs = w[25:21]; e.rt = w[20:16];
    if (op == 0 && r_alu.exists(fn)) begin
      e.alu = r_alu[fn];
      e.dest = w[15:11];
      e.rw = 1'b1;
      if (fn <= 3) e.imm = {27'b0, w[10:6]};
    end else if (i_alu.exists(op)) begin
      e.alu = i_alu[op];
      e.ity = 1'b1;
      e.dest = w[20:16];
      e.imm = (op == 12 || op == 13 || op == 15) ? ze : se;
      e.rw = (op != 'h2B);
      e.mr = (op == 'h23);
      e.mw = (op == 'h2B);
    end else if (op == 4 || op == 5 || op == 7 || (op == 1 && rtf == 1)) begin
      e.alu = (op == 4) ? 5'b10010 : (op == 5) ? 5'b10110 : (op == 7) ? 5'b10011 : 5'b10100;
      e.imm = se;
      e.br = 1'b1;
    end else begin
      e.alu = 5'b11111;
      e.ill = 1'b1;
    end
    if (e.dest == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: begin w[31:26] = 6'h00; w[5:0] = funct_pool[$urandom_range(0, 11)]; end
      2: w[31:26] = op_pool[$urandom_range(0, 11)];
      default: begin w[31:26] = 6'h01; w[20:16] = 5'd1; end
    endcase
    return w;
  endfunction

  // Monitor: check DUT state against scoreboard, then advance the scoreboard for the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
`ifdef ID_SKID_EN
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
`else
      chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
`endif
      if (out_valid && q.size() > 0) begin
        chk("pc_out", pc_out, q[0].pc);
        chk("aluctrl", 32'(aluctrl), 32'(q[0].alu));
        chk("i_type", 32'(i_type), 32'(q[0].ity));
        chk("imm", imm, q[0].imm);
        chk("rs", 32'(rs), 32'(q[0].rs));
        chk("rt", 32'(rt), 32'(q[0].rt));
        chk("dest", 32'(dest), 32'(q[0].dest));
        chk("ctrl{rw,mr,mw,br,ill}", 32'({reg_write, mem_read, mem_write, branch, illegal}),
            32'({q[0].rw, q[0].mr, q[0].mw, q[0].br, q[0].ill}));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(model(instr, pc_in));
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    bit done;
    done = 0;
    in_valid = 1'b1; instr = w; pc_in = pc;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready, expected acceptance of 0x%0h", w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    r_alu['h20] = 5'b00010; r_alu['h21] = 5'b00010;
    r_alu['h22] = 5'b00110; r_alu['h23] = 5'b00110;
    r_alu['h24] = 5'b00000; r_alu['h25] = 5'b00001;
    r_alu['h27] = 5'b01100; r_alu['h2A] = 5'b10000;
    r_alu['h00] = 5'b01101; r_alu['h02] = 5'b01110; r_alu['h03] = 5'b01111;
    i_alu['h08] = 5'b00010; i_alu['h09] = 5'b00010; i_alu['h0A] = 5'b10000;
    i_alu['h0C] = 5'b00000; i_alu['h0D] = 5'b00001; i_alu['h0F] = 5'b10101;
    i_alu['h23] = 5'b00010; i_alu['h2B] = 5'b00010;
    funct_pool = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h3F};
    op_pool    = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07, 6'h3F};

    // Reset state
    idle(3);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset pc_out", pc_out, 32'd0);
    chk("reset imm", imm, 32'd0);
    chk("reset fields", 32'({aluctrl, i_type, rs, rt, dest, reg_write, mem_read, mem_write, branch, illegal}), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;

    // Directed decode: addi, ori, sra, illegal, sll r0
    out_ready = 1'b1;
    send(32'h2022FFFC, 32'h100);
    send(32'h34038000, 32'h104);
    send(32'h000520C3, 32'h108);
    send(32'hFC000000, 32'h10C);
    send(32'h00000000, 32'h110);
    idle(3);

    // Back-to-back with a 3-cycle output stall
    out_ready = 1'b0;
    fork
      begin send(32'h2022FFFC, 32'h200); send(32'h34038000, 32'h204); end
      begin idle(4); out_ready = 1'b1; end
    join
    idle(3);

    // Flush with a held output and a simultaneous incoming instruction
    out_ready = 1'b0;
    send(32'h2022FFFC, 32'h300);
    in_valid = 1'b1; instr = 32'h34038000; pc_in = 32'h304; flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(2);

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    send(32'h2022FFFC, 32'h400);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(out_valid), 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd0);
    chk("async reset pc_out", pc_out, 32'd0);
    chk("async reset imm", imm, 32'd0);
    chk("async reset fields", 32'({aluctrl, i_type, rs, rt, dest, reg_write, mem_read, mem_write, branch, illegal}), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h2022FFFC, 32'h500);
    idle(2);

    // Randomized traffic with backpressure and occasional flushes
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = gen_instr();
      pc_in     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      idle(1);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(5);
    chk("drain", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
